microseq_next_addr: RTL and testbench

- Parametrised microprogram sequencer: holds the control address register (CAR) and selects the next microinstruction address each cycle.
- Sources for the next address: CAR+1, conditional or unconditional branch address, register-supplied address, or a subroutine return address from an internal LIFO stack.
- Successor to the fixed 2-bit-select, single-Z-flag next-address mux. Adds selectable condition flags with polarity, call/return with a return stack, stall, halt, and sticky error flags.
- Sits between control memory (supplies bs, cond_sel, ps, br_addr) and the datapath (supplies cond_flags, reg_addr).

---
 rtl/microseq_pkg.sv | 21 ++
 rtl/micro_ret_stack.sv | 50 +++++
 rtl/microseq_next_addr.sv | 112 +++++++++++
 tb/tb_microseq_next_addr.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/microseq_pkg.sv
// Shared definitions for the microprogram sequencer: next-address mode
// encodings and the stack-pointer width helper.
package microseq_pkg;

    typedef enum logic [2:0] {
        BS_INC   = 3'b000,
        BS_BRC   = 3'b001,
        BS_JMP   = 3'b010,
        BS_JREG  = 3'b011,
        BS_CALL  = 3'b100,
        BS_RET   = 3'b101,
        BS_CCALL = 3'b110,
        BS_HALT  = 3'b111
    } bs_e;

    // Stack occupancy runs 0..depth inclusive, so it needs one extra code.
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/micro_ret_stack.sv
// Return-address LIFO for the microsequencer. The caller guarantees push and
// pop are never asserted together and never overflow/underflow the stack.
module micro_ret_stack
    import microseq_pkg::*;
#(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SPW   = sp_width(DEPTH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic [AW-1:0]  din,
    output logic [AW-1:0]  top,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] mem [2**IW];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;

    assign wr_idx  = sp[IW-1:0];
    assign top_idx = IW'(sp - SPW'(1));
    assign top     = mem[top_idx];
    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);

    // Entries are left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + SPW'(1);
        end else if (pop) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/microseq_next_addr.sv
// Microprogram sequencer: holds the control address register and selects the
// next microaddress from increment, branch, register, or return-stack sources.
module microseq_next_addr
    import microseq_pkg::*;
#(
    parameter int unsigned   AW          = 8,
    parameter int unsigned   NCOND       = 4,
    parameter int unsigned   STACK_DEPTH = 4,
    parameter logic [AW-1:0] RESET_ADDR  = '0,
    parameter int unsigned   CSW         = $clog2(NCOND),
    parameter int unsigned   SPW         = sp_width(STACK_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [2:0]       bs,
    input  logic [CSW-1:0]   cond_sel,
    input  logic             ps,
    input  logic [NCOND-1:0] cond_flags,
    input  logic [AW-1:0]    br_addr,
    input  logic [AW-1:0]    reg_addr,
    output logic [AW-1:0]    car,
    output logic [SPW-1:0]   sp,
    output logic             stack_ovf,
    output logic             stack_unf,
    output logic             halted,
    input  logic             clr_err
);

    bs_e           mode;
    logic          take;
    logic [AW-1:0] inc;
    logic [AW-1:0] car_nxt;
    logic          do_push;
    logic          do_pop;
    logic          ovf_set;
    logic          unf_set;
    logic [AW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;

    assign mode   = bs_e'(bs);
    assign take   = cond_flags[cond_sel] ^ ps;
    assign inc    = car + AW'(1);
    assign halted = (mode == BS_HALT) && !stall;

    always_comb begin
        car_nxt = inc;
        do_push = 1'b0;
        do_pop  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (mode)
            BS_INC:  car_nxt = inc;
            BS_BRC:  car_nxt = take ? br_addr : inc;
            BS_JMP:  car_nxt = br_addr;
            BS_JREG: car_nxt = reg_addr;
            BS_CALL, BS_CCALL: begin
                // A not-taken CCALL degenerates to a plain increment.
                if (mode == BS_CALL || take) begin
                    if (!stk_full) begin
                        do_push = 1'b1;
                        car_nxt = br_addr;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            BS_RET: begin
                if (!stk_empty) begin
                    do_pop  = 1'b1;
                    car_nxt = stk_top;
                end else begin
                    unf_set = 1'b1;
                    car_nxt = RESET_ADDR;
                end
            end
            BS_HALT: car_nxt = car;
            default: car_nxt = inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            car       <= RESET_ADDR;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else if (!stall) begin
            car       <= car_nxt;
            // A fresh error outranks a same-cycle clear.
            stack_ovf <= ovf_set | (stack_ovf & !clr_err);
            stack_unf <= unf_set | (stack_unf & !clr_err);
        end
    end

    micro_ret_stack #(
        .AW    (AW),
        .DEPTH (STACK_DEPTH),
        .SPW   (SPW)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (do_push && !stall),
        .pop   (do_pop && !stall),
        .din   (inc),
        .top   (stk_top),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule

// File: tb/tb_microseq_next_addr.sv
// Bench for microseq_next_addr: directed literal checks plus randomized
// stimulus compared every cycle against a queue-based reference model.
module tb_microseq_next_addr;

    localparam logic [7:0] RA = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] bs = 3'd0;
    logic [1:0] cond_sel = 2'd0;
    logic       ps = 1'b0;
    logic [3:0] cond_flags = 4'd0;
    logic [7:0] br_addr = 8'd0;
    logic [7:0] reg_addr = 8'd0;
    logic       clr_err = 1'b0;
    logic [7:0] car;
    logic [2:0] sp;
    logic       stack_ovf;
    logic       stack_unf;
    logic       halted;

    int n_cmp = 0;
    int n_bad = 0;

    microseq_next_addr #(
        .AW          (8),
        .NCOND       (4),
        .STACK_DEPTH (4),
        .RESET_ADDR  (RA)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .bs         (bs),
        .cond_sel   (cond_sel),
        .ps         (ps),
        .cond_flags (cond_flags),
        .br_addr    (br_addr),
        .reg_addr   (reg_addr),
        .car        (car),
        .sp         (sp),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf),
        .halted     (halted),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the return stack is a plain queue of return addresses.
    logic [7:0] m_car;
    logic [7:0] m_stk[$];
    logic       m_ovf;
    logic       m_unf;

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] nxt;
        logic       tk;
        logic       e_ovf;
        logic       e_unf;
        if (!rst_n) begin
            m_car = RA;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!stall) begin
            tk    = cond_flags[cond_sel] ^ ps;
            nxt   = m_car + 8'd1;
            e_ovf = 1'b0;
            e_unf = 1'b0;
            case (bs)
                3'd1: if (tk) nxt = br_addr;
                3'd2: nxt = br_addr;
                3'd3: nxt = reg_addr;
                3'd4, 3'd6: begin
                    if (bs == 3'd4 || tk) begin
                        if (m_stk.size() < 4) begin
                            m_stk.push_back(m_car + 8'd1);
                            nxt = br_addr;
                        end else begin
                            e_ovf = 1'b1;
                        end
                    end
                end
                3'd5: begin
                    if (m_stk.size() > 0) begin
                        nxt = m_stk.pop_back();
                    end else begin
                        e_unf = 1'b1;
                        nxt   = RA;
                    end
                end
                3'd7: nxt = m_car;
                default: ;
            endcase
            m_car = nxt;
            m_ovf = e_ovf | (m_ovf & !clr_err);
            m_unf = e_unf | (m_unf & !clr_err);
        end
    end

    // Single compare process, sampled on the falling edge.
    always @(negedge clk) begin
        check("car", car, m_car);
        check("sp", sp, m_stk.size());
        check("stack_ovf", stack_ovf, m_ovf);
        check("stack_unf", stack_unf, m_unf);
        check("halted", halted, (bs == 3'd7 && !stall) ? 1 : 0);
    end

    // Apply one command, let the clock edge take it, return just after the edge.
    task automatic op(input logic [2:0] b, input logic [7:0] br = 8'h00,
                      input logic st = 1'b0, input logic clr = 1'b0);
        bs      = b;
        br_addr = br;
        stall   = st;
        clr_err = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #3;
        check("reset_car", car, 8'h00);
        check("reset_sp", sp, 0);
        check("reset_flags", {stack_ovf, stack_unf, halted}, 0);
        #9 rst_n = 1'b1;

        // Increment and wrap
        op(3'd0); check("inc1", car, 8'h01);
        op(3'd0); check("inc2", car, 8'h02);
        op(3'd0); check("inc3", car, 8'h03);
        op(3'd2, 8'hFF); check("jmp_ff", car, 8'hFF);
        op(3'd0); check("inc_wrap", car, 8'h00);

        // Conditional branch with polarity
        op(3'd2, 8'h10);
        cond_sel = 2'd2; cond_flags = 4'b0100; ps = 1'b0;
        op(3'd1, 8'h40); check("brc_taken", car, 8'h40);
        op(3'd2, 8'h10);
        ps = 1'b1;
        op(3'd1, 8'h40); check("brc_not_taken", car, 8'h11);
        ps = 1'b0;

        // Nested call/return
        op(3'd2, 8'h05);
        op(3'd4, 8'h20); check("call1_car", car, 8'h20); check("call1_sp", sp, 1);
        op(3'd4, 8'h30); check("call2_car", car, 8'h30); check("call2_sp", sp, 2);
        op(3'd5);        check("ret1_car", car, 8'h21);  check("ret1_sp", sp, 1);
        op(3'd5);        check("ret2_car", car, 8'h06);  check("ret2_sp", sp, 0);

        // Overflow on the fifth call
        for (int unsigned i = 0; i < 4; i++) op(3'd4, 8'h50);
        op(3'd4, 8'h50);
        check("ovf_car", car, 8'h51);
        check("ovf_sp", sp, 4);
        check("ovf_flag", stack_ovf, 1);
        op(3'd0, 8'h00, 1'b0, 1'b1); check("ovf_clr", stack_ovf, 0);

        // Drain, then underflow; clear is ignored under stall, loses to a new error
        for (int unsigned i = 0; i < 4; i++) op(3'd5);
        check("drained_sp", sp, 0);
        op(3'd2, 8'h33);
        op(3'd5); check("unf_car", car, RA); check("unf_flag", stack_unf, 1);
        op(3'd0, 8'h00, 1'b1, 1'b1); check("clr_stalled", stack_unf, 1);
        op(3'd5, 8'h00, 1'b0, 1'b1); check("clr_vs_new_err", stack_unf, 1);

        // Stall and halt
        op(3'd2, 8'h12);
        bs = 3'd2; br_addr = 8'h77; stall = 1'b1; #1;
        check("stall_halted", halted, 0);
        op(3'd2, 8'h77, 1'b1); check("stall_car", car, 8'h12);
        bs = 3'd7; stall = 1'b0; #1;
        check("halt_flag", halted, 1);
        op(3'd7); check("halt_car", car, 8'h12);

        // Async reset mid-call
        op(3'd4, 8'h60);
        op(3'd4, 8'h70);
        check("pre_rst_sp", sp, 2);
        rst_n = 1'b0; #1;
        check("arst_car", car, 8'h00);
        check("arst_sp", sp, 0);
        check("arst_unf", stack_unf, 0);
        bs = 3'd0; #1 rst_n = 1'b1;

        // Randomized run against the model
        for (int unsigned i = 0; i < 3000; i++) begin
            cond_sel   = 2'($urandom_range(0, 3));
            ps         = 1'($urandom_range(0, 1));
            cond_flags = 4'($urandom);
            reg_addr   = 8'($urandom);
            op(3'($urandom_range(0, 7)), 8'($urandom),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
